// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, PC stage state encoding and sign extension helper
package cpu_pkg;
   localparam int PC_W = 32;
   localparam int OFFSET_W = 8;
   typedef enum logic [1:0] {RUN, STALL, STALL_REDIR} pc_state_t;
   function automatic logic [PC_W-1:0] sign_extend(input logic [OFFSET_W-1:0] v);
      return {{(PC_W-OFFSET_W){v[OFFSET_W-1]}}, v};
   endfunction
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: base + (sign-extended offset << shift), modulo 2^32
module branch_target_adder
   import cpu_pkg::*;
#(
   parameter int SHIFT = 2
) (
   input  logic [PC_W-1:0]     base,
   input  logic [OFFSET_W-1:0] offset,
   output logic [PC_W-1:0]     target
);
   assign target = base + (sign_extend(offset) << SHIFT);
endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter with stall hold and stall-time redirect latch
module pc_update_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'd0,
   parameter int OFFSET_SHIFT = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                BUSYWAIT,
   input  logic                JUMP,
   input  logic                BRANCH,
   input  logic                BRANCH_NE,
   input  logic                ZERO,
   input  logic [OFFSET_W-1:0] OFFSET,
   output logic [PC_W-1:0]     PC,
   output logic [PC_W-1:0]     PC_PLUS4,
   output logic                REDIRECT_PENDING
);
   pc_state_t state, state_n;
   logic [PC_W-1:0] pend_target, pend_n, pc_n, target;
   logic take;
   assign PC_PLUS4 = PC + 32'd4;
   assign take = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);
   assign REDIRECT_PENDING = (state == STALL_REDIR);
   branch_target_adder #(.SHIFT(OFFSET_SHIFT)) u_bta (
      .base(PC_PLUS4),
      .offset(OFFSET),
      .target(target)
   );
   // next PC / state: RUN and STALL share behaviour; STALL_REDIR ignores new takes
   always_comb begin
      state_n = state;
      pend_n = pend_target;
      pc_n = PC;
      case (state)
         RUN, STALL: begin
            if (BUSYWAIT) begin
               state_n = take ? STALL_REDIR : STALL;
               pend_n = take ? target : pend_target;
            end else begin
               state_n = RUN;
               pc_n = take ? target : PC_PLUS4;
            end
         end
         STALL_REDIR: begin
            if (!BUSYWAIT) begin
               state_n = RUN;
               pc_n = pend_target;
            end
         end
         default: state_n = RUN;
      endcase
   end
   // state, PC and pending target registers; reset discards any pending redirect
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= RUN;
         PC <= RESET_PC;
         pend_target <= '0;
      end else begin
         state <= state_n;
         PC <= pc_n;
         pend_target <= pend_n;
      end
   end
endmodule
